// File: rtl/lock_pkg.sv
// Shared types and width helpers for the multi-digit combination lock.
package lock_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    SET     = 2'd2,
    LOCKOUT = 2'd3
  } lock_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_edge_det.sv
// Rising-edge pulse generator for one already-debounced push button.
module lock_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic btn_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) btn_q <= 1'b0;
    else        btn_q <= btn;
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/digital_lock_ctrl.sv
// Multi-digit combination lock: digit capture, code compare, retry counting,
// timed lockout and code change while open.
module digital_lock_ctrl
  import lock_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000,
  parameter logic [DIGITS*DIGIT_W-1:0] RESET_CODE = '0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enter,
  input  logic                                change,
  input  logic [DIGIT_W-1:0]                  sw,
  output logic                                unlocked,
  output logic                                alarm,
  output logic [1:0]                          state_code,
  output logic [width_of(DIGITS)-1:0]         digit_idx,
  output logic [width_of(MAX_TRIES+1)-1:0]    tries_left
);

  localparam int IDX_W   = width_of(DIGITS);
  localparam int TRIES_W = width_of(MAX_TRIES + 1);
  localparam int CNT_W   = width_of(LOCK_CYCLES);
  localparam int CODE_W  = DIGITS * DIGIT_W;
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(LOCK_CYCLES - 1);

  lock_state_t          state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [TRIES_W-1:0]   tries_reg, tries_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [CODE_W-1:0]    code_reg, code_next;
  logic [DIGIT_W-1:0]   buf_mem [DIGITS-1];
  logic [(DIGITS-1)*DIGIT_W-1:0] buf_flat;
  logic [CODE_W-1:0]    entry;
  logic                 buf_we, press_e, press_c, last_digit;

  lock_edge_det u_edge_enter (.clock(clock), .reset(reset), .btn(enter),  .press(press_e));
  lock_edge_det u_edge_change(.clock(clock), .reset(reset), .btn(change), .press(press_c));

  // Slot 0 lands in the most significant digit of the packed entry.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS - 1; gi++) begin : g_flat
      assign buf_flat[(DIGITS-1-gi)*DIGIT_W-1 -: DIGIT_W] = buf_mem[gi];
    end
  endgenerate

  assign entry      = {buf_flat, sw};
  assign last_digit = (idx_reg == IDX_W'(DIGITS - 1));

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tries_next = tries_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    buf_we     = 1'b0;
    case (state_reg)
      LOCKED: begin
        if (press_e) begin
          if (!last_digit) begin
            buf_we   = 1'b1;
            idx_next = idx_reg + 1'b1;
          end else begin
            idx_next = '0;
            if (entry == code_reg) begin
              state_next = OPEN;
              tries_next = TRIES_MAX;
            end else if (tries_reg > TRIES_W'(1)) begin
              tries_next = tries_reg - 1'b1;
            end else begin
              tries_next = '0;
              state_next = LOCKOUT;
              cnt_next   = CNT_LOAD;
            end
          end
        end else if (press_c) begin
          idx_next = '0;
        end
      end
      OPEN: begin
        if (press_e) begin
          state_next = LOCKED;
          idx_next   = '0;
        end else if (press_c) begin
          state_next = SET;
          idx_next   = '0;
        end
      end
      SET: begin
        // Change aborts even when it coincides with an enter press.
        if (press_c) begin
          state_next = OPEN;
          idx_next   = '0;
        end else if (press_e) begin
          if (!last_digit) begin
            buf_we   = 1'b1;
            idx_next = idx_reg + 1'b1;
          end else begin
            code_next  = entry;
            state_next = OPEN;
            idx_next   = '0;
          end
        end
      end
      LOCKOUT: begin
        if (cnt_reg == '0) begin
          state_next = LOCKED;
          tries_next = TRIES_MAX;
          idx_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = LOCKED;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= LOCKED;
      idx_reg   <= '0;
      tries_reg <= TRIES_MAX;
      cnt_reg   <= '0;
      code_reg  <= RESET_CODE;
      for (int i = 0; i < DIGITS - 1; i++) buf_mem[i] <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      tries_reg <= tries_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
      if (buf_we) buf_mem[idx_reg] <= sw;
    end
  end

  assign unlocked   = (state_reg == OPEN) || (state_reg == SET);
  assign alarm      = (state_reg == LOCKOUT);
  assign state_code = state_reg;
  assign digit_idx  = idx_reg;
  assign tries_left = tries_reg;

endmodule
